// File: rtl/ssd_scan_driver_if.sv
// Display-side bundle for the seven-segment scan driver: enable/value in,
// segment/anode drive and frame strobe out.
interface ssd_scan_driver_if;
    logic        en;
    logic [15:0] bcd;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    modport master (output en, output bcd, input seg, input dp, input an, input frame_done);
    modport slave  (input en, input bcd, output seg, output dp, output an, output frame_done);
endinterface

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver: one anode per slot, BCD word
// latched once per frame, leading-zero blanking and dash for non-decimal nibbles.
module ssd_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          AN_ACT_LOW  = 1'b1,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    ssd_scan_driver_if.slave   bus
);
    localparam int unsigned    DW       = $clog2(REFRESH_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SEG_OFF  = {7{SEG_ACT_LOW}};
    localparam logic [3:0]     AN_OFF   = {4{AN_ACT_LOW}};

    logic [DW-1:0] div_q, div_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          fd_q, fd_d;

    logic          tick;
    logic [1:0]    next_idx;
    logic [15:0]   next_shadow;
    logic [3:0]    digit;
    logic [3:0]    lz;
    logic [6:0]    seg_hi;

    always_comb begin
        tick        = bus.en & (div_q == DIV_LAST);
        next_idx    = tick ? idx_q + 2'd1 : idx_q;
        next_shadow = (tick && idx_q == 2'd3) ? bus.bcd : shadow_q;

        unique case (next_idx)
            2'd0:    digit = next_shadow[3:0];
            2'd1:    digit = next_shadow[7:4];
            2'd2:    digit = next_shadow[11:8];
            default: digit = next_shadow[15:12];
        endcase

        // lz[k]: digit k and every digit above it are zero; digit 0 is never blanked
        lz[3] = BLANK_LZ && (next_shadow[15:12] == 4'd0);
        lz[2] = lz[3] && (next_shadow[11:8] == 4'd0);
        lz[1] = lz[2] && (next_shadow[7:4] == 4'd0);
        lz[0] = 1'b0;

        unique case (digit)
            4'd0:    seg_hi = 7'h3F;
            4'd1:    seg_hi = 7'h06;
            4'd2:    seg_hi = 7'h5B;
            4'd3:    seg_hi = 7'h4F;
            4'd4:    seg_hi = 7'h66;
            4'd5:    seg_hi = 7'h6D;
            4'd6:    seg_hi = 7'h7D;
            4'd7:    seg_hi = 7'h07;
            4'd8:    seg_hi = 7'h7F;
            4'd9:    seg_hi = 7'h6F;
            default: seg_hi = 7'h40;
        endcase

        div_d    = div_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        seg_d    = seg_q;
        an_d     = an_q;
        fd_d     = 1'b0;

        if (!bus.en) begin
            div_d = '0;
            idx_d = 2'd3;
            seg_d = SEG_OFF;
            an_d  = AN_OFF;
        end else begin
            div_d = tick ? '0 : div_q + DW'(1);
            if (tick) begin
                idx_d    = next_idx;
                shadow_d = next_shadow;
                fd_d     = (idx_q == 2'd3);
                if (lz[next_idx]) begin
                    seg_d = SEG_OFF;
                    an_d  = AN_OFF;
                end else begin
                    seg_d = SEG_ACT_LOW ? ~seg_hi : seg_hi;
                    an_d  = AN_ACT_LOW ? ~(4'd1 << next_idx) : (4'd1 << next_idx);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            idx_q    <= 2'd3;
            shadow_q <= '0;
            seg_q    <= SEG_OFF;
            an_q     <= AN_OFF;
            fd_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            fd_q     <= fd_d;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.dp         = SEG_ACT_LOW;
    assign bus.frame_done = fd_q;
endmodule
